// File: rtl/pio_port_ctrl.sv
// One Z8420-style PIO port channel: control-word sequencer, mode 0/1/3 data path, handshake, interrupt source.
// Latency: control/data writes take effect on the next clock; pin edge -> RDY/INTI is 1 cycle (+2 with PIO_IN_SYNC_EN).
// Backpressure: none on the host bus. The peripheral is paced by RDY/STB_n. A full input register drops further strobes.
//
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   WR_DATA, CTRL_WE    host write data, control-word write strobe
//   DATA_WE, DATA_RE    output-register write strobe, input-register read strobe
//   DO                  host read data (PO in mode 0, input register in mode 1, pin/PO merge in mode 3)
//   PI, PO, PDIR        pin inputs, output register, per-bit drive enable (1 = drive)
//   STB_n, RDY          peripheral handshake
//   INTI, INTEN, VECT   interrupt pulse, enable and vector to the daisy-chain stage
//   MODE                current port mode
//
// Build option: define PIO_IN_SYNC_EN to pass STB_n and PI through a 2-flop synchronizer
// when the pins are asynchronous to CLK. The default build samples them directly.

module pio_port_ctrl #(
    parameter logic [7:0] VEC_RESET  = 8'h00,
    parameter logic [1:0] MODE_RESET = 2'b01
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] WR_DATA,
    input  logic       CTRL_WE,
    input  logic       DATA_WE,
    input  logic       DATA_RE,
    output logic [7:0] DO,
    input  logic [7:0] PI,
    output logic [7:0] PO,
    output logic [7:0] PDIR,
    input  logic       STB_n,
    output logic       RDY,
    output logic       INTI,
    output logic       INTEN,
    output logic [7:0] VECT,
    output logic [1:0] MODE
);

    typedef enum logic [1:0] {
        CW_IDLE    = 2'd0,
        CW_IOMASK  = 2'd1,
        CW_INTMASK = 2'd2
    } cw_state_t;

    cw_state_t  cw_state, cw_state_nxt;

    // Decoded control-word actions for the current cycle.
    logic       wr_vec, wr_mode, wr_icw, wr_ien, wr_iomask, wr_intmask;

    logic [7:0] iomask, intmask;
    logic       andor, hilo;
    logic       in_full;
    logic       stb_cap;     // current strobe captured data, so its release raises INTI
    logic [7:0] din;
    logic       stb_q;
    logic       match_q;

    logic [7:0] pi_in;
    logic       stb_in;

    // ------------------------------------------------------------------
    // Pin sampling
    // ------------------------------------------------------------------
`ifdef PIO_IN_SYNC_EN
    logic [7:0] pi_s1, pi_s2;
    logic       stb_s1, stb_s2;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pi_s1  <= 8'h00;
            pi_s2  <= 8'h00;
            stb_s1 <= 1'b1;
            stb_s2 <= 1'b1;
        end else begin
            pi_s1  <= PI;
            pi_s2  <= pi_s1;
            stb_s1 <= STB_n;
            stb_s2 <= stb_s1;
        end
    end

    assign pi_in  = pi_s2;
    assign stb_in = stb_s2;
`else
    assign pi_in  = PI;
    assign stb_in = STB_n;
`endif

    // ------------------------------------------------------------------
    // Mode decode and edge / match detection
    // ------------------------------------------------------------------
    logic       is_m0, is_m1, is_m3;
    logic       stb_fall, stb_rise, rd_block;
    logic [7:0] mon, act;
    logic       match;

    assign is_m0 = (MODE == 2'b00);
    assign is_m3 = (MODE == 2'b11);
    assign is_m1 = !is_m0 && !is_m3;   // 10 (bidirectional) runs as input

    assign stb_fall = stb_q & ~stb_in;
    assign stb_rise = ~stb_q & stb_in;

    // A read that coincides with a falling strobe wins. Holding stb_q presents
    // the same falling edge again next cycle, against the emptied register.
    assign rd_block = is_m1 & DATA_RE & stb_fall;

    assign mon = iomask & ~intmask;
    assign act = hilo ? pi_in : ~pi_in;

    always_comb begin
        match = 1'b0;
        if (andor) match = (&(act | ~mon)) & (|mon);
        else       match = |(act & mon);
    end

    // ------------------------------------------------------------------
    // Control-word sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) cw_state <= CW_IDLE;
        else       cw_state <= cw_state_nxt;
    end

    always_comb begin
        cw_state_nxt = cw_state;
        wr_vec       = 1'b0;
        wr_mode      = 1'b0;
        wr_icw       = 1'b0;
        wr_ien       = 1'b0;
        wr_iomask    = 1'b0;
        wr_intmask   = 1'b0;
        if (CTRL_WE) begin
            case (cw_state)
                CW_IDLE: begin
                    if (!WR_DATA[0]) begin
                        wr_vec = 1'b1;
                    end else if (WR_DATA[3:0] == 4'b1111) begin
                        wr_mode = 1'b1;
                        if (WR_DATA[7:6] == 2'b11) cw_state_nxt = CW_IOMASK;
                    end else if (WR_DATA[3:0] == 4'b0111) begin
                        wr_icw = 1'b1;
                        if (WR_DATA[4]) cw_state_nxt = CW_INTMASK;
                    end else if (WR_DATA[3:0] == 4'b0011) begin
                        wr_ien = 1'b1;
                    end
                end
                CW_IOMASK: begin
                    wr_iomask    = 1'b1;
                    cw_state_nxt = CW_IDLE;
                end
                CW_INTMASK: begin
                    wr_intmask   = 1'b1;
                    cw_state_nxt = CW_IDLE;
                end
                default: cw_state_nxt = CW_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers and data path
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            MODE    <= MODE_RESET;
            VECT    <= VEC_RESET;
            INTEN   <= 1'b0;
            PO      <= 8'h00;
            RDY     <= 1'b0;
            INTI    <= 1'b0;
            din     <= 8'h00;
            iomask  <= 8'hFF;
            intmask <= 8'hFF;
            andor   <= 1'b0;
            hilo    <= 1'b0;
            in_full <= 1'b0;
            stb_cap <= 1'b0;
            stb_q   <= 1'b1;
            match_q <= 1'b0;
        end else begin
            INTI <= 1'b0;
            if (!rd_block) stb_q <= stb_in;

            if (DATA_WE) PO <= WR_DATA;

            if (is_m0) begin
                if (DATA_WE)  RDY  <= 1'b1;
                if (stb_fall) RDY  <= 1'b0;
                if (stb_rise) INTI <= 1'b1;
            end

            if (is_m1) begin
                if (DATA_RE) begin
                    in_full <= 1'b0;
                    RDY     <= 1'b1;
                end else if (stb_fall && !in_full) begin
                    din     <= pi_in;
                    in_full <= 1'b1;
                    RDY     <= 1'b0;
                    stb_cap <= 1'b1;
                end
                if (stb_rise) begin
                    INTI    <= stb_cap;
                    stb_cap <= 1'b0;
                end
            end

            // Pulse only on the 0->1 transition of the match condition.
            match_q <= is_m3 & match;
            if (is_m3 && match && !match_q) INTI <= 1'b1;

            if (wr_vec) VECT <= {WR_DATA[7:1], 1'b0};
            if (wr_icw) begin
                INTEN <= WR_DATA[7];
                andor <= WR_DATA[6];
                hilo  <= WR_DATA[5];
            end
            if (wr_ien)    INTEN  <= WR_DATA[7];
            if (wr_iomask) iomask <= WR_DATA;
            if (wr_intmask) begin
                intmask <= WR_DATA;
                match_q <= 1'b0;   // re-arm: an already-true match fires once
            end

            // A mode word overrides any same-cycle handshake update. Input
            // modes come up ready, others idle.
            if (wr_mode) begin
                MODE    <= WR_DATA[7:6];
                RDY     <= (WR_DATA[7:6] == 2'b01) || (WR_DATA[7:6] == 2'b10);
                in_full <= 1'b0;
                stb_cap <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        PDIR = 8'h00;
        DO   = din;
        case (MODE)
            2'b00: begin
                PDIR = 8'hFF;
                DO   = PO;
            end
            2'b11: begin
                PDIR = ~iomask;
                DO   = (pi_in & iomask) | (PO & ~iomask);
            end
            default: begin
                PDIR = 8'h00;
                DO   = din;
            end
        endcase
    end

endmodule
